// File: rtl/dm_resp_pkg.sv
// Shared types and width constants for the dm_resp data-memory responder.
package dm_resp_pkg;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_LANES = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                 write;
    logic [WORD_W-1:0]    addr;
    logic [WORD_W-1:0]    wdata;
    logic [NUM_LANES-1:0] be;
  } req_t;

endpackage

// File: rtl/dm_resp_ram.sv
// Word-addressed storage with per-byte-lane synchronous write and index read.
module dm_resp_ram
  import dm_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                 clock,
  input  logic [NUM_LANES-1:0] wr_lane_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [WORD_W-1:0]    wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [WORD_W-1:0]    rd_data
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (wr_lane_en[i]) begin
        mem_q[wr_idx][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/dm_resp.sv
// Single-outstanding data-memory responder with fixed access latency.
// Optional byte-lane write enables are enabled with DM_RESP_BYTE_EN_EN.
module dm_resp
  import dm_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WORD_W-1:0]    req_addr,
  input  logic [WORD_W-1:0]    req_wdata,
`ifdef DM_RESP_BYTE_EN_EN
  input  logic [NUM_LANES-1:0] req_be,
`endif
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_W-1:0]    resp_rdata,
  output logic                 resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  req_t                 req_q, req_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [WORD_W-1:0]    resp_rdata_q, resp_rdata_d;

  req_t                 req_in;
  req_t                 cur;
  logic                 accept;
  logic                 enter_resp;
  logic                 misaligned;
  logic [IDX_W-1:0]     idx;
  logic [NUM_LANES-1:0] lane_en;
  logic [WORD_W-1:0]    ram_rdata;
  logic                 unused_addr_bits;

  assign req_in.write = req_write;
  assign req_in.addr  = req_addr;
  assign req_in.wdata = req_wdata;
`ifdef DM_RESP_BYTE_EN_EN
  assign req_in.be    = req_be;
`else
  assign req_in.be    = '1;
`endif

  assign req_ready = reset && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // With LATENCY=1 the access happens on the accept edge, before req_q is loaded.
  assign cur              = (state_q == ST_IDLE) ? req_in : req_q;
  assign idx              = cur.addr[IDX_W+1:2];
  assign misaligned       = (cur.addr[1:0] != 2'b00);
  assign unused_addr_bits = ^cur.addr[WORD_W-1:IDX_W+2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    enter_resp   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d = req_in;
          if (LATENCY == 1) begin
            enter_resp = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!reset) begin
      enter_resp = 1'b0;
    end

    if (enter_resp) begin
      state_d      = ST_RESP;
      resp_valid_d = 1'b1;
      resp_err_d   = misaligned;
      resp_rdata_d = (misaligned || cur.write) ? '0 : ram_rdata;
    end
  end

  assign lane_en = (enter_resp && cur.write && !misaligned) ? cur.be : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  dm_resp_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clock     (clock),
    .wr_lane_en(lane_en),
    .wr_idx    (idx),
    .wr_data   (cur.wdata),
    .rd_idx    (idx),
    .rd_data   (ram_rdata)
  );

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dm_resp.sv
// Randomized self-checking bench for dm_resp against a transaction-level model.
module tb_dm_resp;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WIN   = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = 4'hf;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dm_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DM_RESP_BYTE_EN_EN
    .req_be    (req_be),
`endif
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: memory image plus the one outstanding transaction.
  logic [31:0] mm [DEPTH];
  bit          m_busy = 1'b0;
  int          m_rstart = 0;
  bit          m_err;
  logic [31:0] m_rdata;
  bit          m_pw;
  int unsigned m_idx;
  logic [31:0] m_wd;
  logic [3:0]  m_be;

  initial begin
    forever begin
      bit exp_v;
      @(negedge clock);
      exp_v = m_busy && (cyc >= m_rstart);
      chk("req_ready", 32'(req_ready), 32'(reset && !m_busy));
      chk("resp_valid", 32'(resp_valid), 32'(exp_v));
      if (exp_v) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", 32'(resp_err), 32'(m_err));
      end
      if (!reset) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (req_valid) begin
          m_busy   = 1'b1;
          m_rstart = cyc + int'(LAT);
          m_idx    = (req_addr >> 2) % DEPTH;
          m_err    = (req_addr[1:0] != 2'b00);
          m_rdata  = (m_err || req_write) ? 32'h0 : mm[m_idx];
          m_pw     = req_write && !m_err;
          m_wd     = req_wdata;
`ifdef DM_RESP_BYTE_EN_EN
          m_be     = req_be;
`else
          m_be     = 4'hf;
`endif
        end
      end else if (cyc >= m_rstart && resp_ready) begin
        m_busy = 1'b0;
      end
      if (reset && m_busy && m_pw && cyc == m_rstart - 1) begin
        for (int b = 0; b < 4; b++) begin
          if (m_be[b]) mm[m_idx][b*8 +: 8] = m_wd[b*8 +: 8];
        end
      end
      cyc++;
    end
  end

  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input bit rnd, input bit abort, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    bit          acc;
    bit          got;
    int          k;
    logic [31:0] rd0;
    logic        er0;
    rd = '0; er = 1'b0; lat = 0; acc = 1'b0; got = 1'b0; rd0 = '0; er0 = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clock);
      acc = req_ready;
      @(posedge clock); #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready stayed 0, want 1");
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b0;
    if (abort) begin
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      return;
    end
    k = 0;
    while (k < 100 && !got) begin
      if (rnd) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        resp_ready = ($urandom_range(0, 2) != 0);
      end else begin
        resp_ready = ((k + 1) >= int'(LAT) + hold);
      end
      @(negedge clock);
      k++;
      if (resp_valid) begin
        if (lat == 0) begin
          lat = k; rd0 = resp_rdata; er0 = resp_err;
        end else if (hold > 0) begin
          chk("hold_rdata", resp_rdata, rd0);
          chk("hold_err", 32'(resp_err), 32'(er0));
          chk("hold_req_ready", 32'(req_ready), 32'h0);
        end
        if (resp_ready) begin
          got = 1'b1; rd = resp_rdata; er = resp_err;
        end
      end
      @(posedge clock); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp handshake not seen, want one within 100 cycles");
    end else begin
      @(negedge clock);
      chk("idle_after_resp", 32'(req_ready), 32'h1);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] a;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < int'(WIN); i++) begin
      txn(1'b1, 32'(i) << 2, $urandom, 4'hf, 1'b0, 1'b0, 0, rd, er, lat);
    end

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hf, 1'b0, 1'b0, 0, rd, er, lat);
    chk("t1_wr_err", 32'(er), 32'h0);
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_wr_rdata", rd, 32'h0);
    txn(1'b0, 32'h10, 32'h0, 4'hf, 1'b0, 1'b0, 0, rd, er, lat);
    chk("t1_rd_data", rd, 32'hDEADBEEF);

    txn(1'b0, 32'h13, 32'h0, 4'hf, 1'b0, 1'b0, 0, rd, er, lat);
    chk("t2_err", 32'(er), 32'h1);
    chk("t2_rdata", rd, 32'h0);
    txn(1'b0, 32'h10, 32'h0, 4'hf, 1'b0, 1'b0, 0, rd, er, lat);
    chk("t2_unchanged", rd, 32'hDEADBEEF);

    txn(1'b1, 32'h20, 32'h11111111, 4'hf, 1'b0, 1'b0, 0, rd, er, lat);
    txn(1'b0, 32'h10, 32'h0, 4'hf, 1'b0, 1'b0, 3, rd, er, lat);
    chk("t3_rdata", rd, 32'hDEADBEEF);

    txn(1'b1, 32'h20, 32'h22222222, 4'hf, 1'b0, 1'b1, 0, rd, er, lat);
    repeat (4) begin
      @(negedge clock);
      chk("t4_no_resp", 32'(resp_valid), 32'h0);
      @(posedge clock); #1;
    end
    txn(1'b0, 32'h20, 32'h0, 4'hf, 1'b0, 1'b0, 0, rd, er, lat);
    chk("t4_rd_old", rd, 32'h11111111);

    txn(1'b1, 32'h1000, 32'h12345678, 4'hf, 1'b0, 1'b0, 0, rd, er, lat);
    txn(1'b0, 32'h0, 32'h0, 4'hf, 1'b0, 1'b0, 0, rd, er, lat);
    chk("t5_wrap", rd, 32'h12345678);

`ifdef DM_RESP_BYTE_EN_EN
    txn(1'b1, 32'h0, 32'h0, 4'hf, 1'b0, 1'b0, 0, rd, er, lat);
    txn(1'b1, 32'h0, 32'hAABBCCDD, 4'b0010, 1'b0, 1'b0, 0, rd, er, lat);
    txn(1'b0, 32'h0, 32'h0, 4'b0101, 1'b0, 1'b0, 0, rd, er, lat);
    chk("t6_byte_en", rd, 32'h0000CC00);
`endif

    for (int t = 0; t < 300; t++) begin
      a = (32'($urandom_range(0, 15)) << 12) | (32'($urandom_range(0, WIN - 1)) << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b1,
          ($urandom_range(0, 19) == 0), 0, rd, er, lat);
    end

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from request accept to resp_valid (legal range 1..15).
REQ-003 The block SHALL have port clock  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning a synchronous, active-low reset.
REQ-005 The block SHALL have ports req_valid in 1, req_ready out 1, req_write in 1, req_addr in 32, req_wdata in 32, meaning the request channel from the CPU memory stage.
REQ-006 The block SHALL have ports resp_valid out 1, resp_ready in 1, resp_rdata out 32, resp_err out 1, meaning the response channel back to the CPU.

Function
REQ-007 The block SHALL implement states IDLE, WAIT and RESP.
REQ-008 A request SHALL be accepted on an edge where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-009 On accept, the block SHALL capture write, addr and wdata, load the wait counter with LATENCY-1 and enter WAIT, or enter RESP directly when LATENCY=1.
REQ-010 In WAIT, the counter SHALL decrement each cycle; at zero the block SHALL enter RESP, so resp_valid first asserts exactly LATENCY cycles after the accept edge.
REQ-011 The array write and the read-data capture SHALL occur on the edge entering RESP, and only then.
REQ-012 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-013 If addr[1:0] is not 0, the block SHALL skip the array write, drive resp_err=1 and resp_rdata=0 in RESP.
REQ-014 A write SHALL return resp_rdata=0; a read SHALL return the word stored at the index.
REQ-015 In RESP, resp_valid, resp_rdata and resp_err SHALL stay stable until resp_ready=1; on that edge the block SHALL return to IDLE.
REQ-016 A new request SHALL NOT be accepted on the response-handshake edge, giving at least one idle cycle between transactions.
REQ-017 req_valid asserted outside IDLE SHALL be ignored and left pending for the requester.

Reset
REQ-018 While reset=0 at an edge, the state SHALL go to IDLE, the counter to 0, and resp_valid, resp_err and resp_rdata to 0; req_ready SHALL be 0 in any cycle where reset=0.
REQ-019 A reset asserted in WAIT SHALL abort the transaction with no array write and no response.
REQ-020 Array contents SHALL NOT be reset.

Configuration
REQ-021 With macro DM_RESP_BYTE_EN_EN defined, the block SHALL add input req_be (4 bits), and a write SHALL update only the byte lanes whose req_be bit is 1; a read SHALL ignore req_be.
REQ-022 Without DM_RESP_BYTE_EN_EN defined, the req_be port SHALL be absent and every write SHALL update the full word.

Structure
REQ-023 Package dm_resp_pkg SHALL hold the state enum, the counter width constant (4) and the word/byte width constants.
REQ-024 The storage array SHALL be a separate sub-module dm_resp_ram, with a synchronous write port that takes a per-lane enable and an index-addressed read.

Verification
REQ-025 Test 1, LATENCY=2: write 0xDEADBEEF to 0x10, accepted at cycle 0 -> resp_valid=1 at cycle 2 with resp_err=0; a following read of 0x10 -> resp_rdata=0xDEADBEEF.
REQ-026 Test 2: read 0x13 -> resp_err=1, resp_rdata=0, and the word at 0x10 is unchanged.
REQ-027 Test 3: hold resp_ready=0 for 3 cycles in RESP -> resp_valid, resp_rdata and resp_err stay constant and req_ready=0 throughout; IDLE one cycle after resp_ready=1.
REQ-028 Test 4: word 0x20 holds 0x11111111; write 0x22222222 to 0x20 and assert reset during WAIT -> no response, and a later read of 0x20 returns 0x11111111.
REQ-029 Test 5, DEPTH_WORDS=1024: write 0x12345678 to 0x1000 -> a read of 0x0 returns 0x12345678.
REQ-030 Test 6, DM_RESP_BYTE_EN_EN defined: word 0x0 holds 0x00000000; write 0xAABBCCDD with req_be=4'b0010 -> a read returns 0x0000CC00.
